// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Single-outstanding ICache fetcher feeding a PC/instruction FIFO;
//            FETCH_PREFETCH_EN enables back-to-back requests on each response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_next,
  output logic [XLEN-1:0] addr,
  output logic            rn,
  input  logic [XLEN-1:0] inst,
  input  logic            read_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pred_next,
  input  logic            deq
);

  localparam int                 c_ptr_w = $clog2(QUEUE_DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                rn_q, rn_d;
  logic [c_ptr_w-1:0]  head_q, head_d;
  logic [c_ptr_w-1:0]  tail_q, tail_d;
  logic [c_cnt_w-1:0]  count_q, count_d;
  logic [XLEN-1:0]     mem_inst_q [QUEUE_DEPTH];
  logic [XLEN-1:0]     mem_pc_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]     mem_pn_q   [QUEUE_DEPTH];
  logic                w_push;
  logic                w_pop;

  assign pred_pc       = pc_q;
  assign addr          = addr_q;
  assign rn            = rn_q;
  assign out_valid     = (count_q != '0);
  assign out_inst      = mem_inst_q[head_q];
  assign out_pc        = mem_pc_q[head_q];
  assign out_pred_next = mem_pn_q[head_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    rn_d    = rn_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    if (flush) begin
      // A response landing with the flush is simply dropped; otherwise it is
      // still owed by the ICache and must be absorbed in DISCARD.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = flush_pc;
      rn_d    = 1'b0;
      if (state_q == S_WAIT) begin
        state_d = read_ready ? S_IDLE : S_DISCARD;
      end
    end else begin
      w_pop = deq && out_valid;
      case (state_q)
        S_IDLE: begin
          if (count_q < c_full) begin
            addr_d  = pc_q;
            rn_d    = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (read_ready) begin
            w_push = 1'b1;
            pc_d   = pred_next;
`ifdef FETCH_PREFETCH_EN
            if ((count_q + c_cnt_w'(1) - c_cnt_w'(w_pop)) < c_full) begin
              addr_d = pred_next;
            end else begin
              rn_d    = 1'b0;
              state_d = S_IDLE;
            end
`else
            rn_d    = 1'b0;
            state_d = S_IDLE;
`endif
          end
        end
        S_DISCARD: begin
          if (read_ready) begin
            rn_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (w_push) tail_d = tail_q + c_ptr_w'(1);
      if (w_pop)  head_d = head_q + c_ptr_w'(1);
      count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      rn_q    <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rn_q    <= rn_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_push) begin
      mem_inst_q[tail_q] <= inst;
      mem_pc_q[tail_q]   <= pc_q;
      mem_pn_q[tail_q]   <= pred_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction fetcher. It issues one ICache read at a time and follows the branch predictor's next-PC. Fetched instructions are buffered in a QUEUE_DEPTH-entry FIFO together with their PC and predicted next-PC. The block sits between the ICache and the decoder, and accepts a redirect (flush) from the ROB on mispredict.

Parameters:
XLEN, 32, width of PC, instruction and address buses.
QUEUE_DEPTH, 4, FIFO entries; power of two, >= 2.
RESET_PC, 0, PC loaded on reset.

Ports:
clk  in  1  system clock
rst  in  1  reset
rdy  in  1  global ready; when low, every register holds its value
pred_pc  out  XLEN  current fetch PC, presented to predictor (combinational from PC register)
pred_next  in  XLEN  predictor's next-PC for pred_pc (PC+4 or predicted target)
addr  out  XLEN  ICache read address; only bits 17:0 are used downstream
rn  out  1  ICache read enable; held high until read_ready
inst  in  XLEN  ICache data, valid when read_ready=1
read_ready  in  1  ICache response strobe, one cycle per request
flush  in  1  redirect request from ROB
flush_pc  in  XLEN  redirect target
out_valid  out  1  FIFO non-empty
out_inst  out  XLEN  head instruction
out_pc  out  XLEN  head PC
out_pred_next  out  XLEN  head predicted next-PC
deq  in  1  decoder pops head; ignored when out_valid=0

Behaviour:
- Reset: one clock, synchronous, active-high (rst). rst takes priority over rdy.
- Reset values: PC=RESET_PC, addr=0, rn=0, head=tail=count=0, out_valid=0, state=IDLE.
- rdy=0: no state, pointer or output change. ICache responses arriving in that cycle are not captured; the ICache holds read_ready until rdy returns.
- FSM states: IDLE, WAIT, DISCARD.
- IDLE:
  - If count<QUEUE_DEPTH and no flush: addr<=PC, rn<=1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, read_ready=0: hold addr and rn.
- WAIT, read_ready=1:
  - Push {inst, PC, pred_next} at tail; PC<=pred_next; rn<=0; go to IDLE.
  - The write is visible on out_* the next cycle if the FIFO was empty.
- DISCARD: the outstanding response belongs to a squashed path. On read_ready, drop the data, rn<=0, go to IDLE. No push.
- flush=1 (any state): head=tail=count=0, PC<=flush_pc, rn<=0.
  - From WAIT with read_ready=0: go to DISCARD.
  - From WAIT with read_ready=1: the response is dropped; go to IDLE.
  - From IDLE or DISCARD: state unchanged (DISCARD keeps waiting).
  - deq in the same cycle is ignored.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH. count is clog2(QUEUE_DEPTH)+1 bits wide.
- Full (count==QUEUE_DEPTH): no new request is issued. The in-flight request can never overflow, because issue requires count<QUEUE_DEPTH and only one request is outstanding.
- Baseline throughput: one instruction per 3 cycles with a 1-cycle ICache (issue, response, return to IDLE).

Optional Feature:
FETCH_PREFETCH_EN
- With the macro defined: on a WAIT response, if (count + 1 - (deq && out_valid)) < QUEUE_DEPTH and there is no flush:
  - Issue the next request in the same cycle: addr<=pred_next, rn stays 1, remain in WAIT.
  - pred_pc already reflects the updated PC on the following cycle.
  - Throughput reaches one instruction per ICache latency.
- Without the macro: always return to IDLE after a response (baseline above).

Test Plan:
1. Reset with RESET_PC=0; predictor returns PC+4; ICache answers 1 cycle after rn -> rn rises with addr 0x0, then 0x4 and 0x8; FIFO holds PCs 0,4,8 with matching inst; out_valid=1 after the first response.
2. deq held low, QUEUE_DEPTH=4 -> exactly 4 requests issued, then rn stays 0 and count=4. A single deq pulse -> a fifth request issues the next cycle.
3. Flush with flush_pc=0x100 while in WAIT, read_ready arriving 2 cycles later with inst 0xDEAD -> 0xDEAD never enqueued; out_valid=0; next request addr=0x100.
4. Flush coincident with read_ready and deq, FIFO holding 2 entries -> count=0, nothing pushed, next addr=flush_pc.
5. rdy=0 for 5 cycles mid-WAIT -> addr, rn, count and out_* unchanged; operation resumes correctly when rdy returns.
6. With FETCH_PREFETCH_EN and a 1-cycle ICache -> requests on consecutive cycles (0x0, 0x4, 0xC when pred_next(0x4)=0xC); FIFO full after 4 with no overflow.
